// File: rtl/arbitro_escritura.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbitro_escritura: round-robin arbiter for the register-file write port
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module arbitro_escritura #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter bit PROTECT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_address,
  output logic [DATA_W-1:0] reg_data_in,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_count
);

  logic              w_transfer;
  logic              w_conflict;
  logic              w_zero_block;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign w_transfer   = req0_ready || req1_ready;
  assign w_conflict   = req0_valid && req1_valid && !hold;
  assign w_addr       = req1_ready ? req1_addr : req0_addr;
  assign w_data       = req1_ready ? req1_data : req0_data;
  assign w_zero_block = PROTECT_ZERO && (w_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write      <= 1'b0;
      reg_address    <= '0;
      reg_data_in    <= '0;
      last_grant     <= 1'b1;
      conflict_count <= '0;
    end else begin
      reg_write <= w_transfer && !w_zero_block;
      if (w_transfer) begin
        reg_address <= w_addr;
        reg_data_in <= w_data;
        last_grant  <= req1_ready;
      end
      // Debug counter saturates so a long stall cannot make it look quiet.
      if (w_conflict && (conflict_count != '1)) begin
        conflict_count <= conflict_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_escritura.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_arbitro_escritura: directed + randomized self-checking bench
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_arbitro_escritura;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hold = 1'b0;
  logic              v0 = 1'b0, v1 = 1'b0;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0;
  logic [DATA_W-1:0] d0 = '0, d1 = '0;
  logic              req0_ready, req1_ready, reg_write, last_grant;
  logic [ADDR_W-1:0] reg_address;
  logic [DATA_W-1:0] reg_data_in;
  logic [CNT_W-1:0]  conflict_count;

  arbitro_escritura #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .PROTECT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(req1_ready),
    .reg_write(reg_write), .reg_address(reg_address), .reg_data_in(reg_data_in),
    .last_grant(last_grant), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the port must show after the last edge.
  logic              m_last;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_cnt;
  logic              t0, t1;
  int                wait0 = 0, wait1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who wins this cycle: 0 none, 1 requester 0, 2 requester 1.
  function automatic int winner(input logic q0, input logic q1, input logic h, input logic last);
    if (h) return 0;
    if (q0 && q1) return last ? 1 : 2;
    if (q0) return 1;
    if (q1) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    m_last = 1'b1; m_write = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
    wait0 = 0; wait1 = 0;
  endtask

  // Advance one clock edge and apply the arbitration rules to the model.
  task automatic step();
    int w;
    w = winner(v0, v1, hold, m_last);
    @(posedge clk);
    t0 = 1'b0; t1 = 1'b0;
    if (!rst) begin
      if (v0 && v1 && !hold && m_cnt < CMAX) m_cnt++;
      if (w == 0) m_write = 1'b0;
      else begin
        t0 = (w == 1); t1 = (w == 2);
        m_last  = t1;
        m_addr  = t1 ? a1 : a0;
        m_data  = t1 ? d1 : d0;
        m_write = (m_addr != 0);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
    m_reset();
    step();
    rst = 1'b0;
  endtask

  // Compare process: every cycle outside reset, DUT against model.
  always @(negedge clk) begin
    int w;
    if (!rst) begin
      w = winner(v0, v1, hold, m_last);
      chk("req0_ready", req0_ready, w == 1);
      chk("req1_ready", req1_ready, w == 2);
      chk("reg_write", reg_write, m_write);
      chk("reg_address", reg_address, m_addr);
      chk("reg_data_in", reg_data_in, m_data);
      chk("last_grant", last_grant, m_last);
      chk("conflict_count", conflict_count, m_cnt);
      if (!v0) wait0 = 0;
      else if (!hold) begin
        wait0 = req0_ready ? 0 : wait0 + 1;
        chk("starve0", wait0 <= 1, 1'b1);
      end
      if (!v1) wait1 = 0;
      else if (!hold) begin
        wait1 = req1_ready ? 0 : wait1 + 1;
        chk("starve1", wait1 <= 1, 1'b1);
      end
    end
  end

  initial begin
    m_reset();
    t0 = 1'b0; t1 = 1'b0;
    do_reset();
    step();
    chk("rst_write", reg_write, 1'b0);
    chk("rst_last", last_grant, 1'b1);
    chk("rst_cnt", conflict_count, 0);

    // Single request
    v0 = 1'b1; a0 = 16'd4; d0 = 32'hACEDCAFE;
    #1 chk("single_ready0", req0_ready, 1'b1);
    step(); v0 = 1'b0;
    chk("single_wr", reg_write, 1'b1);
    chk("single_addr", reg_address, 16'd4);
    chk("single_data", reg_data_in, 32'hACEDCAFE);
    step();
    chk("single_wr_off", reg_write, 1'b0);

    // Tie after reset
    do_reset();
    v0 = 1'b1; a0 = 16'd3; d0 = 32'hDEADBEEF;
    v1 = 1'b1; a1 = 16'd5; d1 = 32'h12345678;
    #1 chk("tie_ready0", req0_ready, 1'b1);
    step(); v0 = 1'b0;
    chk("tie_addr0", reg_address, 16'd3);
    chk("tie_cnt", conflict_count, 1);
    #1 chk("tie_ready1", req1_ready, 1'b1);
    step(); v1 = 1'b0;
    chk("tie_addr1", reg_address, 16'd5);
    chk("tie_wr1", reg_write, 1'b1);

    // Sustained contention
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; a0 = 16'(i + 1); d0 = $urandom;
      v1 = 1'b1; a1 = 16'(i + 9); d1 = $urandom;
      #1 chk("alt_ready0", req0_ready, (i % 2) == 0);
      step();
      chk("alt_wr", reg_write, 1'b1);
    end
    chk("alt_cnt", conflict_count, 6);
    chk("alt_last", last_grant, 1'b1);

    // Hold
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
      step();
      chk("hold_wr", reg_write, 1'b0);
    end
    chk("hold_cnt", conflict_count, 6);
    chk("hold_last", last_grant, 1'b1);
    hold = 1'b0;
    #1 chk("release_ready0", req0_ready, 1'b1);
    step();
    chk("release_cnt", conflict_count, 7);
    step();
    chk("sat_cnt", conflict_count, 7);
    v0 = 1'b0; v1 = 1'b0;

    // Address zero
    v1 = 1'b1; a1 = '0; d1 = 32'hFFFFFFFF;
    #1 chk("zero_ready1", req1_ready, 1'b1);
    step(); v1 = 1'b0;
    chk("zero_last", last_grant, 1'b1);
    chk("zero_wr", reg_write, 1'b0);
    chk("zero_data", reg_data_in, 32'hFFFFFFFF);

    // Reset mid-operation
    v0 = 1'b1; a0 = 16'd7; d0 = 32'h0BADF00D;
    step(); v0 = 1'b0;
    chk("mid_wr_before", reg_write, 1'b1);
    #1 rst = 1'b1; m_reset();
    #1 chk("mid_wr_drop", reg_write, 1'b0);
    chk("mid_cnt", conflict_count, 0);
    chk("mid_last", last_grant, 1'b1);
    step(); rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; a0 = 16'd2; a1 = 16'd6;
    #1 chk("mid_tie_ready0", req0_ready, 1'b1);
    step(); v0 = 1'b0;
    step(); v1 = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!v0 || t0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 16'($urandom_range(0, 15)); d0 = $urandom;
      end
      if (!v1 || t1) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = 16'($urandom_range(0, 15)); d1 = $urandom;
      end
      hold = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/arbitro_escritura.md
Name: arbitro_escritura

Overview:
- Two-requester arbiter for the single write port of the register file (module Registro: data_in, address1, write, clk).
- Requester 0 (ALU writeback) and requester 1 (load unit) each present valid/addr/data; the block grants at most one per cycle with round-robin fairness.
- The winner is registered and presented to the register file one cycle later as a single-cycle write strobe.
- Provides a hold input for pipeline stalls and a contention counter for debug.

Parameters:
- ADDR_W, 16, register address width (matches Registro address ports).
- DATA_W, 32, write data width.
- CNT_W, 16, width of contention counter.
- PROTECT_ZERO, 1, when 1 writes to address 0 are accepted but never strobed to the register file.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- hold  input  1  when 1, no grants issued this cycle.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_W  requester 0 target register.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  grant to requester 0 (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_W  requester 1 target register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  grant to requester 1 (combinational).
- reg_write  output  1  write strobe to register file (registered).
- reg_address  output  ADDR_W  write address to register file (registered).
- reg_data_in  output  DATA_W  write data to register file (registered).
- last_grant  output  1  ID of most recent winner (registered).
- conflict_count  output  CNT_W  cycles in which both requests were valid and hold=0.

Behaviour:
- Reset (async, immediate): reg_write=0, reg_address=0, reg_data_in=0, last_grant=1 (so requester 0 wins the first tie), conflict_count=0. A write registered but not yet strobed is dropped.
- Grant logic (combinational, same cycle): hold=1 -> both ready=0. Only one valid -> that one ready=1. Both valid -> ready goes to requester != last_grant. Ready never asserts without its valid.
- Transfer = valid && ready. Requesters hold valid/addr/data stable until transfer. No data is ever dropped; the loser retries next cycle.
- Output stage: on the transfer edge, reg_address/reg_data_in load the winner's addr/data, and reg_write=1 for exactly the next cycle. With no transfer, reg_write=0 and addr/data hold their previous value. Latency from transfer to strobe visible: 1 cycle. Throughput: 1 write/cycle.
- last_grant updates only on a transfer; unchanged during idle or hold.
- PROTECT_ZERO=1 and winner addr==0: transfer completes (ready=1, last_grant updates), but reg_write stays 0 that cycle. reg_address/reg_data_in still load.
- Same address from both requesters in one cycle: loser's write lands one cycle after the winner's, so it is the final value. No merging.
- conflict_count increments when req0_valid && req1_valid && !hold. Saturates at all-ones (no wrap).
- Starvation bound: a continuously valid requester is granted within 2 non-hold cycles.

Test Plan:
- Reset then single request: req0 addr=4 data=ACEDCAFE, others idle -> req0_ready=1 same cycle; next cycle reg_write=1, reg_address=4, reg_data_in=ACEDCAFE; following cycle reg_write=0.
- Tie after reset: req0 (addr=3, DEADBEEF) and req1 (addr=5, 12345678) held valid -> cycle0 grants 0, cycle1 grants 1; strobes addr 3 then 5 on consecutive cycles; conflict_count=1 after cycle0.
- Sustained contention: both valid for 6 cycles, each re-presenting after grant -> grants alternate 0,1,0,1,0,1; reg_write high 6 consecutive cycles; conflict_count=6.
- Hold: both valid with hold=1 for 3 cycles -> no ready, reg_write=0, conflict_count unchanged, last_grant unchanged; on hold release the grant goes to the requester != last_grant.
- Address zero: req1 addr=0 data=FFFFFFFF with PROTECT_ZERO=1 -> req1_ready=1, last_grant=1, reg_write stays 0; readback of register 0 unchanged.
- Reset mid-operation: transfer to addr=7, assert rst before the next edge -> reg_write drops to 0 immediately, register 7 not written; conflict_count=0; after release, first tie goes to requester 0.
